// File: rtl/dmem_copy_engine.sv
// Bus-master copy/fill engine for the 32 x 16 data memory.
// Every output is a register loaded together with the next state, so none of them can glitch.
module dmem_copy_engine #(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          mode_i,
  input  logic [AW-1:0] src_i,
  input  logic [AW-1:0] dst_i,
  input  logic [AW:0]   len_i,
  input  logic [DW-1:0] fill_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] Addr_o,
  output logic [DW-1:0] data_o,
  output logic          WEn_o,
  input  logic [DW-1:0] data_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);

  state_t        state_r;
  logic [AW-1:0] sa_r;
  logic [AW-1:0] da_r;
  logic [AW:0]   cnt_r;
  logic [DW-1:0] buf_r;
  logic          mode_r;
  logic          busy_r;
  logic          done_r;
  logic          wen_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;

  // Transfer sequencer; outputs default to the idle bus pattern and are overridden for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      sa_r    <= '0;
      da_r    <= '0;
      cnt_r   <= '0;
      buf_r   <= '0;
      mode_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      wen_r   <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      wen_r   <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            sa_r   <= src_i;
            da_r   <= dst_i;
            cnt_r  <= len_i;
            mode_r <= mode_i;
            buf_r  <= fill_i;
            if (len_i == CNT_ZERO) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else if (!mode_i) begin
              state_r <= ST_READ;
              busy_r  <= 1'b1;
              addr_r  <= src_i;
            end else begin
              state_r <= ST_WRITE;
              busy_r  <= 1'b1;
              wen_r   <= 1'b1;
              addr_r  <= dst_i;
              wdata_r <= fill_i;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          // The word read now is written straight out in the following WRITE cycle.
          buf_r   <= data_i;
          sa_r    <= sa_r + ADDR_ONE;
          state_r <= ST_WRITE;
          busy_r  <= 1'b1;
          wen_r   <= 1'b1;
          addr_r  <= da_r;
          wdata_r <= data_i;
        end
        ST_WRITE: begin
          da_r  <= da_r + ADDR_ONE;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else if (!mode_r) begin
            state_r <= ST_READ;
            busy_r  <= 1'b1;
            addr_r  <= sa_r;
          end else begin
            state_r <= ST_WRITE;
            busy_r  <= 1'b1;
            wen_r   <= 1'b1;
            addr_r  <= da_r + ADDR_ONE;
            wdata_r <= buf_r;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_r;
  assign done_o = done_r;
  assign WEn_o  = wen_r;
  assign Addr_o = addr_r;
  assign data_o = wdata_r;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Scoreboard bench for dmem_copy_engine: a word-level transfer model predicts writes, done timing and final memory.
module tb_dmem_copy_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        mode_i;
  logic [4:0]  src_i;
  logic [4:0]  dst_i;
  logic [5:0]  len_i;
  logic [15:0] fill_i;
  logic        busy_o;
  logic        done_o;
  logic [4:0]  Addr_o;
  logic [15:0] data_o;
  logic        WEn_o;
  logic [15:0] data_i;

  logic [15:0] mem [32];
  logic [15:0] mem_model [32];
  logic [15:0] pre_img [32];
  logic        pre_req = 1'b0;
  logic        mon_en = 1'b0;

  logic [20:0] exp_wr [$];
  int          exp_done [$];
  int          exp_busy [$];
  int          cyc = 0;
  int          busy_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  dmem_copy_engine #(.AW(5), .DW(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .src_i(src_i), .dst_i(dst_i),
    .len_i(len_i), .fill_i(fill_i), .busy_o(busy_o), .done_o(done_o), .Addr_o(Addr_o),
    .data_o(data_o), .WEn_o(WEn_o), .data_i(data_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: combinational read, falling-edge write, bench-side preload
  assign data_i = mem[Addr_o];
  always @(negedge clk) begin
    if (pre_req) begin
      for (int k = 0; k < 32; k++) mem[k] <= pre_img[k];
    end else if (WEn_o === 1'b1) begin
      mem[Addr_o] <= data_o;
    end
  end

  // Monitor: idle bus pattern, write stream and done timing against the scoreboard queues
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy_o !== 1'b1) begin
        checks++;
        if (WEn_o !== 1'b0 || Addr_o !== 5'd0 || data_o !== 16'd0) begin
          errors++;
          $display("FAIL idle_bus cyc=%0d got wen=%b addr=%0d data=%h need 0/0/0", cyc, WEn_o, Addr_o, data_o);
        end
      end
      if (WEn_o === 1'b1) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL wr_extra cyc=%0d got addr=%0d data=%h need no write", cyc, Addr_o, data_o);
        end else begin
          logic [20:0] e;
          e = exp_wr.pop_front();
          if ({Addr_o, data_o} !== e) begin
            errors++;
            $display("FAIL wr_txn cyc=%0d got addr=%0d data=%h need addr=%0d data=%h",
                     cyc, Addr_o, data_o, e[20:16], e[15:0]);
          end
        end
      end
      if (done_o === 1'b1) begin
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL done_extra cyc=%0d got done=1 need 0", cyc);
        end else begin
          int ec;
          int eb;
          ec = exp_done.pop_front();
          eb = exp_busy.pop_front();
          if (cyc != ec || busy_cnt != eb) begin
            errors++;
            $display("FAIL done_time got cyc=%0d busy=%0d need cyc=%0d busy=%0d", cyc, busy_cnt, ec, eb);
          end
        end
      end
      if (busy_o === 1'b1) busy_cnt = busy_cnt + 1;
      else if (done_o !== 1'b1) busy_cnt = 0;
    end
  end

  task automatic preload(input int kind);
    for (int k = 0; k < 32; k++) begin
      case (kind)
        0: pre_img[k] = 16'h1000 + 16'(k);
        1: pre_img[k] = 16'(k);
        2: pre_img[k] = 16'h2000 + 16'(k);
        default: pre_img[k] = 16'($urandom);
      endcase
      mem_model[k] = pre_img[k];
    end
    pre_req = 1'b1;
    @(negedge clk);
    #1;
    pre_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Reference: ascending word moves with wrap; only the first nlim words are applied
  task automatic model_push(input logic m, input int s, input int d, input int n, input logic [15:0] f,
                            input int nlim);
    for (int i = 0; i < n && i < nlim; i++) begin
      logic [15:0] v;
      int ad;
      ad = (d + i) % 32;
      v = m ? f : mem_model[(s + i) % 32];
      mem_model[ad] = v;
      exp_wr.push_back({5'(ad), v});
    end
  endtask

  task automatic drive_start(input logic m, input int s, input int d, input int n, input logic [15:0] f);
    start_i = 1'b1;
    mode_i  = m;
    src_i   = 5'(s);
    dst_i   = 5'(d);
    len_i   = 6'(n);
    fill_i  = f;
  endtask

  task automatic rand_start();
    drive_start(1'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(1, 32)), 16'($urandom));
  endtask

  task automatic do_xfer(input logic m, input int s, input int d, input int n, input logic [15:0] f,
                         input bit ign);
    int t;
    int off;
    off = (n == 0) ? 0 : (m ? n : 2 * n);
    model_push(m, s, d, n, f, 64);
    drive_start(m, s, d, n, f);
    @(posedge clk);
    #1;
    t = cyc;
    start_i = 1'b0;
    exp_done.push_back(t + off);
    exp_busy.push_back(off);
    if (ign && off >= 4) begin
      while (cyc < t + 2) begin @(posedge clk); #1; end
      rand_start();
      @(posedge clk);
      #1;
      start_i = 1'b0;
    end
    while (cyc < t + off) begin @(posedge clk); #1; end
    if (ign) rand_start();
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (mem[k] !== mem_model[k]) begin
        errors++;
        $display("FAIL mem_%s word %0d got %h need %h", tag, k, mem[k], mem_model[k]);
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || WEn_o !== 1'b0 || Addr_o !== 5'd0 || data_o !== 16'd0) begin
      errors++;
      $display("FAIL %s got busy=%b done=%b wen=%b addr=%0d data=%h need all 0",
               tag, busy_o, done_o, WEn_o, Addr_o, data_o);
    end
  endtask

  initial begin
    int t;
    rst = 1'b1;
    drive_start(1'b0, 0, 0, 0, 16'h0);
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset_state");
    rst = 1'b0;
    mon_en = 1'b1;

    // Directed: basic copy, wrapping fill, zero length, overlapping copies
    preload(0);
    do_xfer(1'b0, 2, 20, 5, 16'h0, 1'b0);
    check_mem("copy5");
    do_xfer(1'b1, 29, 0, 6, 16'hBEEF, 1'b0);
    check_mem("fill_wrap");
    do_xfer(1'b0, 7, 9, 0, 16'h0, 1'b0);
    check_mem("len0");
    preload(1);
    do_xfer(1'b0, 0, 1, 4, 16'h0, 1'b0);
    check_mem("ovl_up");
    preload(1);
    do_xfer(1'b0, 4, 0, 4, 16'h0, 1'b0);
    check_mem("ovl_down");
    do_xfer(1'b0, 30, 30, 4, 16'h0, 1'b1);
    check_mem("self_copy_ign");
    do_xfer(1'b1, 10, 12, 7, 16'h5A5A, 1'b1);
    check_mem("fill_ign");

    // Reset sampled at the edge ending the 2nd write of an 8-word copy
    preload(2);
    model_push(1'b0, 3, 16, 8, 16'h0, 2);
    drive_start(1'b0, 3, 16, 8, 16'h0);
    @(posedge clk);
    #1;
    t = cyc;
    start_i = 1'b0;
    while (cyc < t + 3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero_outputs("after_rst");
    repeat (3) @(posedge clk);
    #1;
    check_mem("rst_mid");
    do_xfer(1'b0, 16, 0, 3, 16'h0, 1'b0);
    check_mem("post_rst");

    // Randomized back-to-back transfers
    for (int it = 0; it < 24; it++) begin
      int n;
      if ($urandom_range(0, 2) == 0) preload(3);
      n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 32));
      do_xfer(1'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), n,
              16'($urandom), ($urandom_range(0, 3) == 0));
      check_mem("rand");
    end

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_wr.size() != 0 || exp_done.size() != 0) begin
      errors++;
      $display("FAIL pending got writes=%0d dones=%0d need 0/0", exp_wr.size(), exp_done.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
